// File: rtl/serial_alu_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_pkg
// Description : Shared opcode and state encodings for the bit-serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_PASSA = 3'b101,
    OP_PASSB = 3'b110,
    OP_NOTA  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_alu_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_engine_if
// Description : Control/data bundle between a driver and the serial ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_alu_engine_if #(
  parameter int WIDTH = 8
);
  import serial_alu_pkg::*;

  logic             din;
  logic             load;
  logic             start;
  op_e              op;
  logic             rd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             dout;

  modport master (
    output din, load, start, op, rd,
    input  busy, done, result, carry, zero, dout
  );

  modport slave (
    input  din, load, start, op, rd,
    output busy, done, result, carry, zero, dout
  );

endinterface
`default_nettype wire

// File: rtl/serial_alu_engine_bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_bit
// Description : One-bit combinational ALU slice; B is inverted here for SUB so
//               the caller only supplies raw operand bits and the carry flop.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_bit
  import serial_alu_pkg::*;
(
  input  wire logic a,
  input  wire logic b,
  input  wire logic cin,
  input  wire op_e  op,
  output logic      r,
  output logic      cout
);

  logic bx;

  // Full-adder path with optional B inversion, plus the bitwise operations
  always_comb begin
    bx   = (op == OP_SUB) ? ~b : b;
    cout = (a & bx) | (a & cin) | (bx & cin);
    r    = 1'b0;
    case (op)
      OP_ADD, OP_SUB: r = a ^ bx ^ cin;
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_XOR:         r = a ^ b;
      OP_PASSA:       r = a;
      OP_PASSB:       r = b;
      OP_NOTA:        r = ~a;
      default:        r = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/serial_alu_engine.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_engine
// Description : Bit-serial ALU. Operands shift in from din, the operation runs
//               LSB-first one bit per clock, and the operands rotate back to
//               their original position so operations can be chained.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_engine
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input wire logic          clk,
  input wire logic          rst,
  serial_alu_engine_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e               state;
  op_e                  op_q;
  logic [2*WIDTH-1:0]   opnd;     // A = upper half, B = lower half
  logic [WIDTH-1:0]     sh;       // result assembles here, MSB-in
  logic [WIDTH-1:0]     result_q;
  logic [CNT_W-1:0]     cnt;
  logic                 cf;       // running carry between bit slices
  logic                 zacc;     // OR of every result bit produced so far
  logic                 busy_q;
  logic                 done_q;
  logic                 carry_q;
  logic                 zero_q;
  logic                 r_bit;
  logic                 c_bit;
  logic                 arith;

  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  serial_alu_bit u_bit (
    .a    (opnd[WIDTH]),
    .b    (opnd[0]),
    .cin  (cf),
    .op   (op_q),
    .r    (r_bit),
    .cout (c_bit)
  );

  // Control FSM with all datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= OP_ADD;
      opnd     <= '0;
      sh       <= '0;
      result_q <= '0;
      cnt      <= '0;
      cf       <= 1'b0;
      zacc     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            cnt    <= '0;
            zacc   <= 1'b0;
            cf     <= (bus.op == OP_SUB);
            busy_q <= 1'b1;
            state  <= EXEC;
          end else if (bus.load) begin
            opnd <= {opnd[2*WIDTH-2:0], bus.din};
          end else if (bus.rd) begin
            result_q <= {result_q[WIDTH-2:0], result_q[WIDTH-1]};
          end
        end
        EXEC: begin
          sh   <= {r_bit, sh[WIDTH-1:1]};
          // Rotate A and B right independently so both return home after WIDTH steps
          opnd <= {opnd[WIDTH], opnd[2*WIDTH-1:WIDTH+1], opnd[0], opnd[WIDTH-1:1]};
          if (arith) cf <= c_bit;
          zacc <= zacc | r_bit;
          cnt  <= cnt + 1'b1;
          // Final bit: publish outputs on this edge so they appear in the DONE cycle
          if (cnt == LAST_BIT) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {r_bit, sh[WIDTH-1:1]};
            zero_q   <= ~(zacc | r_bit);
            if (arith) carry_q <= c_bit;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.dout   = result_q[WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_engine
// Description : Directed self-checking bench for serial_alu_engine (WIDTH 8
//               and a WIDTH 16 instance sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_engine;
  import serial_alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  serial_alu_engine_if #(.WIDTH(8))  bus ();
  serial_alu_engine_if #(.WIDTH(16)) bus16 ();

  serial_alu_engine #(.WIDTH(8))  dut   (.clk(clk), .rst(rst), .bus(bus));
  serial_alu_engine #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] v;
    v = {a, b};
    for (int i = 15; i >= 0; i--) begin
      bus.load = 1'b1;
      bus.din  = v[i];
      step();
    end
    bus.load = 1'b0;
    bus.din  = 1'b0;
  endtask

  // Issues start, checks busy/done/result-hold every EXEC cycle and the
  // done pulse at exactly WIDTH+1 cycles; optionally pokes inputs mid-EXEC.
  task automatic run_op(input op_e o, input logic [7:0] prev, input bit inject);
    bus.start = 1'b1;
    bus.op    = o;
    step();
    bus.start = 1'b0;
    bus.load  = 1'b0;
    bus.din   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("busy_exec", 32'(bus.busy), 32'd1);
      chk("done_early", 32'(bus.done), 32'd0);
      chk("result_hold", 32'(bus.result), 32'(prev));
      if (inject && i == 2) begin
        bus.load = 1'b1; bus.din = 1'b1; bus.rd = 1'b1;
        bus.start = 1'b1; bus.op = OP_NOTA;
      end
      if (inject && i == 3) begin
        bus.load = 1'b0; bus.din = 1'b0; bus.rd = 1'b0;
        bus.start = 1'b0;
      end
      step();
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_clear", 32'(bus.busy), 32'd0);
    step();
    chk("done_single", 32'(bus.done), 32'd0);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] res, input logic c, input logic z);
    chk({tag, "_result"}, 32'(bus.result), 32'(res));
    chk({tag, "_carry"}, 32'(bus.carry), 32'(c));
    chk({tag, "_zero"}, 32'(bus.zero), 32'(z));
  endtask

  initial begin
    logic [7:0]  rb;
    logic [31:0] v16;
    bus.din = 0; bus.load = 0; bus.start = 0; bus.rd = 0; bus.op = OP_ADD;
    bus16.din = 0; bus16.load = 0; bus16.start = 0; bus16.rd = 0; bus16.op = OP_ADD;
    rst = 1'b1;
    step(); step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk_out("rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // ADD with latency checks, then chained ops on preserved operands
    load_ab(8'h5A, 8'h3C);
    run_op(OP_ADD, 8'h00, 1'b0); chk_out("add", 8'h96, 1'b0, 1'b0);
    run_op(OP_AND, 8'h96, 1'b0); chk_out("and", 8'h18, 1'b0, 1'b0);
    run_op(OP_XOR, 8'h18, 1'b0); chk_out("xor", 8'h66, 1'b0, 1'b0);
    run_op(OP_SUB, 8'h66, 1'b0); chk_out("sub", 8'h1E, 1'b1, 1'b0);

    // Overflow to zero, then a logic op that must not touch carry
    load_ab(8'hFF, 8'h01);
    run_op(OP_ADD, 8'h1E, 1'b0);  chk_out("add_ovf", 8'h00, 1'b1, 1'b1);
    run_op(OP_NOTA, 8'h00, 1'b0); chk_out("nota", 8'h00, 1'b1, 1'b1);

    // Borrow case
    load_ab(8'h10, 8'h20);
    run_op(OP_SUB, 8'h00, 1'b0); chk_out("sub_borrow", 8'hF0, 1'b0, 1'b0);

    // start and load together: start wins, operands untouched
    bus.load = 1'b1; bus.din = 1'b1;
    run_op(OP_PASSA, 8'hF0, 1'b0); chk_out("prio_passa", 8'h10, 1'b0, 1'b0);
    run_op(OP_PASSB, 8'h10, 1'b0); chk_out("prio_passb", 8'h20, 1'b0, 1'b0);

    // Inputs poked during EXEC are ignored
    run_op(OP_ADD, 8'h20, 1'b1);   chk_out("inject_add", 8'h30, 1'b0, 1'b0);
    run_op(OP_PASSA, 8'h30, 1'b0); chk_out("inject_opnd", 8'h10, 1'b0, 1'b0);

    // Reset in the 4th EXEC cycle
    bus.start = 1'b1; bus.op = OP_ADD;
    step();
    bus.start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk_out("midrst", 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("midrst_nodone", 32'(bus.done), 32'd0);
      step();
    end
    load_ab(8'h01, 8'h02);
    run_op(OP_ADD, 8'h00, 1'b0); chk_out("post_rst_add", 8'h03, 1'b0, 1'b0);

    // Serial readback
    load_ab(8'h5A, 8'h3C);
    run_op(OP_ADD, 8'h03, 1'b0); chk_out("rb_add", 8'h96, 1'b0, 1'b0);
    rb = 8'h96;
    for (int i = 7; i >= 0; i--) begin
      chk("dout_bit", 32'(bus.dout), 32'(rb[i]));
      bus.rd = 1'b1;
      step();
    end
    bus.rd = 1'b0;
    chk("rb_restore", 32'(bus.result), 32'h96);

    // WIDTH=16 instance: 0x005A + 0x003C
    v16 = 32'h005A_003C;
    for (int i = 31; i >= 0; i--) begin
      bus16.load = 1'b1;
      bus16.din  = v16[i];
      step();
    end
    bus16.load  = 1'b0;
    bus16.din   = 1'b0;
    bus16.start = 1'b1;
    bus16.op    = OP_ADD;
    step();
    bus16.start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      chk("w16_busy", 32'(bus16.busy), 32'd1);
      chk("w16_done_early", 32'(bus16.done), 32'd0);
      step();
    end
    chk("w16_done", 32'(bus16.done), 32'd1);
    chk("w16_result", 32'(bus16.result), 32'h0096);
    chk("w16_carry", 32'(bus16.carry), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_alu_engine.md
Name: serial_alu_engine

Overview:
Parametrised bit-serial ALU, the next generation of the shift-compute tile.
- Two WIDTH-bit operands are loaded serially from a one-bit input.
- The selected operation is computed LSB-first, one bit per clock, with a carry flop; the operands are preserved so operations can be chained without reloading.
- Result and flags are held stable for parallel or serial readback.
- Sits behind the tile's pin-level wrapper; the wrapper maps these ports onto dedicated I/O.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32. CNT_W = clog2(WIDTH) is a derived localparam.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
din  input  1  serial operand data bit
load  input  1  shift din into operand register this cycle (IDLE only)
start  input  1  begin operation (IDLE only)
op  input  3  operation code, sampled on accepted start
rd  input  1  rotate result register left by one (IDLE only)
busy  output  1  high while computing
done  output  1  one-cycle completion pulse
result  output  WIDTH  last completed result
carry  output  1  carry/no-borrow flag of last ADD/SUB
zero  output  1  high if last result == 0
dout  output  1  result[WIDTH-1], serial readback

Behaviour:
- Reset values: busy=0, done=0, result=0, carry=0, zero=0. Operand register, count and state are cleared; state goes to IDLE.
- Operand register opnd[2*WIDTH-1:0] holds A = upper half and B = lower half.
- load in IDLE: opnd <= {opnd[2W-2:0], din}, so the bits are MSB of A first, LSB of B last (2*WIDTH cycles).
- Opcodes (shared package):
  - 000 ADD
  - 001 SUB (A-B)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 PASSA
  - 110 PASSB
  - 111 NOTA
- Same-cycle priority in IDLE: start > load > rd; the lower-priority inputs are ignored that cycle.
- States:
  - IDLE -> EXEC on start: latch op; clear count and zero accumulator; set carry flop to 1 for SUB, else 0.
  - EXEC, WIDTH cycles: each cycle computes bit r from A[0], B[0] (B inverted for SUB) and the carry flop.
    - Shadow register: sh <= {r, sh[W-1:1]}.
    - A and B each rotate right by one.
    - Carry flop updates for ADD/SUB only.
    - zacc |= r.
    - count increments; after the WIDTH-th bit go to DONE.
  - DONE, 1 cycle: done=1; result<=sh; zero<=~zacc; carry<=carry flop (ADD/SUB only; other ops leave carry unchanged). Then IDLE.
- Latency: start sampled at edge T; busy is high for T+1..T+WIDTH; done and the new result are visible in cycle T+WIDTH+1. Total WIDTH+1 cycles start-to-done.
- After EXEC the operands have rotated WIDTH times and are restored exactly, which enables chaining.
- result stays stable throughout EXEC and only changes in DONE.
- SUB: carry=1 means no borrow (A>=B); the result wraps mod 2^WIDTH.
- start/load/rd while busy or in DONE are ignored, with no queuing.
- rd in IDLE: result <= {result[W-2:0], result[W-1]}. dout always equals result[WIDTH-1]; WIDTH rd pulses restore result.
- rst mid-EXEC: abort immediately, no done pulse, all reset values apply.

Decomposition:
- Package serial_alu_pkg:
  - op_e (3-bit opcode enum)
  - state_e (IDLE/EXEC/DONE)
  - OP_W = 3
- Sub-module serial_alu_bit: combinational one-bit slice.
  - Inputs: a, b, cin, op.
  - Outputs: r, cout.
  - Performs SUB inversion internally.
- Top holds the FSM, counter, operand/shadow/result registers and flags.

Test Plan:
- WIDTH=8. Load A=0x5A, B=0x3C (16 load cycles), start ADD at T -> busy T+1..T+8; done only at T+9; result=0x96, carry=0, zero=0.
- Chain without reload: start AND -> result=0x18; then XOR -> 0x66; then SUB -> 0x1E, carry=1. Confirms operands are preserved.
- Load A=0xFF, B=0x01, ADD -> result=0x00, carry=1, zero=1. Load A=0x10, B=0x20, SUB -> 0xF0, carry=0.
- Priority and busy: start+load in the same IDLE cycle -> op runs and operands are unchanged. start/load/rd pulsed during EXEC -> ignored, result unchanged until done, a single done pulse.
- Reset mid-op: rst on the 4th EXEC cycle -> next cycle busy=0, done=0, result=0, carry=0, zero=0. No done pulse follows. A subsequent load/ADD of 0x01+0x02 gives 0x03.
- Readback: with result=0x96, 8 rd pulses -> dout sequence 1,0,0,1,0,1,1,0 (sampled before each rd edge); result=0x96 afterwards. Repeat ADD 0x5A+0x3C at WIDTH=16 -> 0x0096 after 17 cycles.
